decoder3x8_seq: RTL and testbench
=================================

Name: decoder3x8_seq

Overview:
- Sequenced 3-to-8 decoder, the inverse of the team's 8x3 priority encoder.
- Accepts 3-bit index codes over a valid/ready handshake and buffers them in a small FIFO.
- Replays each code as a one-hot 8-bit output held for HOLD cycles.
- Drives one-hot select/strobe lines from index streams produced upstream by the encoder path.

Parameters:
- DEPTH, 4, FIFO entries. Must be a power of two, >= 2.
- HOLD, 1, cycles each one-hot word stays asserted. Must be >= 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  enable; 0 freezes FIFO pop and the hold counter, and blanks out
- in_valid  input  1  in_code is valid
- in_code  input  3  index to decode, 0..7
- in_ready  output  1  FIFO can accept (not full)
- out  output  8  one-hot decoded word, bit in_code set
- out_valid  output  1  out currently carries a decoded word
- fifo_count  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=1 at a clock edge), regardless of state or en:
  - FIFO emptied, fifo_count=0, state=IDLE, hold counter=0, out=8'h00, out_valid=0.
  - in_ready=1 from the first cycle after reset.
  - A handshake presented in the reset cycle is dropped.
- Push:
  - Occurs on an edge where in_valid && in_ready; in_ready = (fifo_count != DEPTH), purely from occupancy.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - Push and pop in the same cycle (not full): fifo_count unchanged.
  - Push is allowed when en=0.
- No bypass: a code pushed into an empty FIFO becomes visible to the FSM on the next cycle.
- FSM states: IDLE, HOLD.
  - IDLE: if en && fifo_count!=0 -> pop; out_valid<=1; out<=8'b1<<code; cnt<=HOLD-1; go HOLD. Otherwise out_valid=0, out=8'h00.
  - HOLD, en=1, cnt!=0: cnt<=cnt-1, out unchanged.
  - HOLD, en=1, cnt==0, FIFO non-empty: pop next code, reload cnt<=HOLD-1, stay HOLD. Back-to-back words, no gap cycle.
  - HOLD, en=1, cnt==0, FIFO empty: out<=8'h00, out_valid<=0, go IDLE.
  - HOLD, en=0: state, cnt and FIFO frozen; out forced to 8'h00 and out_valid to 0 combinationally. Resumes with the remaining count when en returns to 1.
- Latency: code accepted on edge k into an empty FIFO in IDLE with en=1 -> out valid after edge k+1, for exactly HOLD cycles.
- Width rules:
  - out is always exactly one-hot when out_valid=1 and all-zero when out_valid=0.
  - Hold counter width is $clog2(HOLD+1).
  - FIFO pointers are $clog2(DEPTH) bits and wrap naturally; count carries the extra bit to distinguish full from empty.
- Ordering: strict FIFO order, no codes dropped or duplicated.

Optional Feature:
- Macro TRISTATE_OUT_EN.
- Defined: while en=0, out drives 8'bzzzzzzzz (out_valid still 0), matching the encoder's disabled high-impedance convention.
- Not defined: out drives 8'h00 while en=0.
- Reset value of out is 8'h00 in both builds when en=1.

Decomposition:
- Shared package decoder_pkg:
  - CODE_W=3, ONEHOT_W=8.
  - State enum {IDLE, HOLD}.
  - Function onehot(code) returning 8-bit 1<<code.
- Sub-module sync_fifo (parameters WIDTH=CODE_W, DEPTH):
  - push/pop/full/empty/count.
  - Synchronous active-high reset on clk/rst.
  - Reusable by the encoder-side path.
- FSM, hold counter and output mux stay in decoder3x8_seq.

Test Plan:
- Reset then single push, code 3'd5, HOLD=1, en=1 -> out=8'h20, out_valid=1 for exactly one cycle, starting one cycle after the accept edge; then out=8'h00.
- HOLD=3; push 3'd0, 3'd7 back-to-back -> out=8'h01 for 3 cycles, then 8'h80 for 3 cycles with no gap; fifo_count returns to 0.
- DEPTH=4; en=0 with in_valid held, codes 1,2,3,4,5 -> in_ready drops after 4 accepts, fifo_count=4, out=8'h00 (8'hzz with TRISTATE_OUT_EN). Raise en -> outputs 8'h02, 8'h04, 8'h08, 8'h10; code 5 is accepted once space frees.
- HOLD=4; drop en for 2 cycles mid-hold after 2 cycles asserted -> out blanked for 2 cycles, then the same one-hot returns for the remaining 2 cycles.
- Assert rst mid-HOLD with 2 entries queued -> next cycle out=8'h00, out_valid=0, fifo_count=0, in_ready=1; queued codes are never emitted.
- Random push stream of 200 codes with random en -> scoreboard confirms order, one-hot-ness, and HOLD-cycle assertion per code.

Source files
------------

// File: rtl/decoder3x8_seq_pkg.sv
// Shared types and helpers for the 3-to-8 sequenced decoder and its FIFO.
package decoder_pkg;
  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_e;

  function automatic logic [ONEHOT_W-1:0] onehot(input logic [CODE_W-1:0] code);
    onehot = ONEHOT_W'(1) << code;
  endfunction
endpackage

// File: rtl/decoder3x8_seq_if.sv
// Code stream in, one-hot word out, plus enable and FIFO occupancy.
interface decoder3x8_seq_if #(parameter int DEPTH = 4);
  import decoder_pkg::*;
  logic                   en;
  logic                   in_valid;
  logic [CODE_W-1:0]      in_code;
  logic                   in_ready;
  logic [ONEHOT_W-1:0]    out;
  logic                   out_valid;
  logic [$clog2(DEPTH):0] fifo_count;

  modport slave  (input en, in_valid, in_code, output in_ready, out, out_valid, fifo_count);
  modport master (output en, in_valid, in_code, input in_ready, out, out_valid, fifo_count);
endinterface

// File: rtl/decoder3x8_seq_sync_fifo.sv
// Synchronous FIFO, power-of-two depth, sync active-high reset; full refuses push even on pop.
module sync_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/decoder3x8_seq.sv
// Buffers 3-bit codes and replays each as a one-hot word held HOLD cycles.
// Optional TRISTATE_OUT_EN: out floats instead of reading zero while en=0.
module decoder3x8_seq
  import decoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int HOLD  = 1
) (
  input logic              clk,
  input logic              rst,
  decoder3x8_seq_if.slave  bus
);
  localparam int CW = $clog2(HOLD + 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ONEHOT_W-1:0] word_q, word_d;
  logic                pop;
  logic                fifo_full, fifo_empty;
  logic [CODE_W-1:0]   head;

  sync_fifo #(.WIDTH(CODE_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.in_valid),
    .pop_i   (pop),
    .wdata_i (bus.in_code),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (bus.fifo_count)
  );

  assign bus.in_ready = !fifo_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  // en=0 leaves every default in place, freezing state, count and FIFO.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    pop     = 1'b0;
    if (bus.en) begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            word_d  = onehot(head);
            cnt_d   = CW'(HOLD - 1);
            state_d = S_HOLD;
          end else begin
            word_d  = '0;
          end
        end
        S_HOLD: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (!fifo_empty) begin
            pop    = 1'b1;
            word_d = onehot(head);
            cnt_d  = CW'(HOLD - 1);
          end else begin
            word_d  = '0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.out_valid = bus.en && (state_q == S_HOLD);

`ifdef TRISTATE_OUT_EN
  assign bus.out = !bus.en ? {ONEHOT_W{1'bz}} : (bus.out_valid ? word_q : '0);
`else
  assign bus.out = bus.out_valid ? word_q : '0;
`endif
endmodule

// File: tb/tb_decoder3x8_seq.sv
// Three decoders (HOLD=1,3,4) share one stimulus stream; directed tables plus random traffic.
module tb_decoder3x8_seq;
  localparam int NI  = 3;
  localparam int DEP = 4;
`ifdef TRISTATE_OUT_EN
  localparam logic [7:0] DIS = 8'bzzzzzzzz;
`else
  localparam logic [7:0] DIS = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       t_rst, t_en, t_v;
  logic [2:0] t_code;
  always #5 clk = ~clk;

  decoder3x8_seq_if #(.DEPTH(DEP)) if0 ();
  decoder3x8_seq_if #(.DEPTH(DEP)) if1 ();
  decoder3x8_seq_if #(.DEPTH(DEP)) if2 ();
  assign if0.en = t_en; assign if0.in_valid = t_v; assign if0.in_code = t_code;
  assign if1.en = t_en; assign if1.in_valid = t_v; assign if1.in_code = t_code;
  assign if2.en = t_en; assign if2.in_valid = t_v; assign if2.in_code = t_code;

  decoder3x8_seq #(.DEPTH(DEP), .HOLD(1)) u0 (.clk(clk), .rst(t_rst), .bus(if0.slave));
  decoder3x8_seq #(.DEPTH(DEP), .HOLD(3)) u1 (.clk(clk), .rst(t_rst), .bus(if1.slave));
  decoder3x8_seq #(.DEPTH(DEP), .HOLD(4)) u2 (.clk(clk), .rst(t_rst), .bus(if2.slave));

  int nerr = 0, nchk = 0;
  bit mchk = 0;

  // Reference: a queue of pending codes plus the word being shown and cycles left.
  int hv[NI] = '{1, 3, 4};
  int mq[NI][$];
  bit act[NI];
  int cur[NI], left[NI], pushes[NI], vcyc[NI];

  typedef struct {
    string      nm;
    int         inst;
    bit         chk, rst, en, v;
    logic [2:0] code;
    logic [7:0] eo;
    bit         eov;
    int         ecnt;
    bit         erdy;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input string nm, input int inst, input bit chk, input bit rst, input bit en,
                     input bit v, input int code, input logic [7:0] eo, input bit eov,
                     input int ecnt, input bit erdy);
    vec_t r;
    r.nm = nm; r.inst = inst; r.chk = chk; r.rst = rst; r.en = en; r.v = v;
    r.code = 3'(code); r.eo = eo; r.eov = eov; r.ecnt = ecnt; r.erdy = erdy;
    tbl.push_back(r);
  endtask

  task automatic get(input int k, output logic [7:0] o, output logic ov, output logic [2:0] c,
                     output logic r);
    case (k)
      0:       begin o = if0.out; ov = if0.out_valid; c = if0.fifo_count; r = if0.in_ready; end
      1:       begin o = if1.out; ov = if1.out_valid; c = if1.fifo_count; r = if1.in_ready; end
      default: begin o = if2.out; ov = if2.out_valid; c = if2.fifo_count; r = if2.in_ready; end
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic model_check();
    logic [7:0] o; logic ov, r; logic [2:0] c;
    logic [7:0] eo; bit eov;
    for (int k = 0; k < NI; k++) begin
      get(k, o, ov, c, r);
      eov = act[k] && t_en;
      eo  = eov ? 8'(1 << cur[k]) : (t_en ? 8'h00 : DIS);
      chk($sformatf("model_out[%0d]", k), {24'd0, o}, {24'd0, eo});
      chk($sformatf("model_valid[%0d]", k), {31'd0, ov}, {31'd0, eov});
      chk($sformatf("model_count[%0d]", k), {29'd0, c}, 32'(mq[k].size()));
      chk($sformatf("model_ready[%0d]", k), {31'd0, r}, {31'd0, mq[k].size() != DEP});
      if (ov === 1'b1) begin
        vcyc[k]++;
        chk($sformatf("onehot[%0d]", k), {31'd0, $onehot(o)}, 32'd1);
      end
    end
  endtask

  task automatic model_step();
    int n;
    bit popnow;
    for (int k = 0; k < NI; k++) begin
      if (t_rst) begin
        mq[k].delete(); act[k] = 0; left[k] = 0;
      end else begin
        n = mq[k].size();
        popnow = 0;
        if (t_en) begin
          if (act[k] && left[k] > 0) left[k]--;
          else if (n > 0) begin
            popnow = 1; act[k] = 1; cur[k] = mq[k][0]; left[k] = hv[k] - 1;
          end else act[k] = 0;
        end
        if (t_v && n < DEP) begin
          mq[k].push_back(int'(t_code));
          pushes[k]++;
        end
        if (popnow) void'(mq[k].pop_front());
      end
    end
  endtask

  task automatic step(input bit row, input vec_t r);
    logic [7:0] o; logic ov, rd; logic [2:0] c;
    @(negedge clk);
    if (row && r.chk) begin
      get(r.inst, o, ov, c, rd);
      chk({r.nm, "_out"}, {24'd0, o}, {24'd0, (r.en ? r.eo : DIS)});
      chk({r.nm, "_valid"}, {31'd0, ov}, {31'd0, r.eov});
      chk({r.nm, "_count"}, {29'd0, c}, 32'(r.ecnt));
      chk({r.nm, "_ready"}, {31'd0, rd}, {31'd0, r.erdy});
    end
    if (mchk) model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t nul;
    nul = '{nm: "", inst: 0, chk: 0, rst: 0, en: 0, v: 0, code: 0, eo: 0, eov: 0, ecnt: 0, erdy: 0};
    // HOLD=1 single word; the handshake in the reset cycle must vanish.
    add("A_rst", 0, 0, 1, 1, 1, 7, 8'h00, 0, 0, 1);
    add("A_idle", 0, 1, 0, 1, 1, 5, 8'h00, 0, 0, 1);
    add("A_q", 0, 1, 0, 1, 0, 0, 8'h00, 0, 1, 1);
    add("A_out", 0, 1, 0, 1, 0, 0, 8'h20, 1, 0, 1);
    add("A_done", 0, 1, 0, 1, 0, 0, 8'h00, 0, 0, 1);
    // HOLD=3 back-to-back words.
    add("B_rst", 1, 0, 1, 1, 1, 3, 8'h00, 0, 0, 1);
    add("B_p0", 1, 1, 0, 1, 1, 0, 8'h00, 0, 0, 1);
    add("B_p7", 1, 1, 0, 1, 1, 7, 8'h00, 0, 1, 1);
    add("B_w0a", 1, 1, 0, 1, 0, 0, 8'h01, 1, 1, 1);
    add("B_w0b", 1, 1, 0, 1, 0, 0, 8'h01, 1, 1, 1);
    add("B_w0c", 1, 1, 0, 1, 0, 0, 8'h01, 1, 1, 1);
    add("B_w7a", 1, 1, 0, 1, 0, 0, 8'h80, 1, 0, 1);
    add("B_w7b", 1, 1, 0, 1, 0, 0, 8'h80, 1, 0, 1);
    add("B_w7c", 1, 1, 0, 1, 0, 0, 8'h80, 1, 0, 1);
    add("B_end", 1, 1, 0, 1, 0, 0, 8'h00, 0, 0, 1);
    // Fill while disabled, then drain; code 5 waits for space.
    add("C_rst", 0, 0, 1, 1, 0, 0, 8'h00, 0, 0, 1);
    add("C_p1", 0, 1, 0, 0, 1, 1, 8'h00, 0, 0, 1);
    add("C_p2", 0, 1, 0, 0, 1, 2, 8'h00, 0, 1, 1);
    add("C_p3", 0, 1, 0, 0, 1, 3, 8'h00, 0, 2, 1);
    add("C_p4", 0, 1, 0, 0, 1, 4, 8'h00, 0, 3, 1);
    add("C_full1", 0, 1, 0, 0, 1, 5, 8'h00, 0, 4, 0);
    add("C_full2", 0, 1, 0, 0, 1, 5, 8'h00, 0, 4, 0);
    add("C_en", 0, 1, 0, 1, 1, 5, 8'h00, 0, 4, 0);
    add("C_w1", 0, 1, 0, 1, 1, 5, 8'h02, 1, 3, 1);
    add("C_w2", 0, 1, 0, 1, 0, 0, 8'h04, 1, 3, 1);
    add("C_w3", 0, 1, 0, 1, 0, 0, 8'h08, 1, 2, 1);
    add("C_w4", 0, 1, 0, 1, 0, 0, 8'h10, 1, 1, 1);
    add("C_w5", 0, 1, 0, 1, 0, 0, 8'h20, 1, 0, 1);
    add("C_end", 0, 1, 0, 1, 0, 0, 8'h00, 0, 0, 1);
    // HOLD=4 with a two-cycle enable drop mid-word.
    add("D_rst", 2, 0, 1, 1, 0, 0, 8'h00, 0, 0, 1);
    add("D_p6", 2, 1, 0, 1, 1, 6, 8'h00, 0, 0, 1);
    add("D_q", 2, 1, 0, 1, 0, 0, 8'h00, 0, 1, 1);
    add("D_h1", 2, 1, 0, 1, 0, 0, 8'h40, 1, 0, 1);
    add("D_h2", 2, 1, 0, 1, 0, 0, 8'h40, 1, 0, 1);
    add("D_off1", 2, 1, 0, 0, 0, 0, 8'h00, 0, 0, 1);
    add("D_off2", 2, 1, 0, 0, 0, 0, 8'h00, 0, 0, 1);
    add("D_h3", 2, 1, 0, 1, 0, 0, 8'h40, 1, 0, 1);
    add("D_h4", 2, 1, 0, 1, 0, 0, 8'h40, 1, 0, 1);
    add("D_end", 2, 1, 0, 1, 0, 0, 8'h00, 0, 0, 1);
    // Reset mid-hold with two codes queued; they must never appear.
    add("E_rst0", 2, 0, 1, 1, 0, 0, 8'h00, 0, 0, 1);
    add("E_p1", 2, 1, 0, 1, 1, 1, 8'h00, 0, 0, 1);
    add("E_p2", 2, 1, 0, 1, 1, 2, 8'h00, 0, 1, 1);
    add("E_p3", 2, 1, 0, 1, 1, 3, 8'h02, 1, 1, 1);
    add("E_rst", 2, 1, 1, 1, 0, 0, 8'h02, 1, 2, 1);
    add("E_a", 2, 1, 0, 1, 0, 0, 8'h00, 0, 0, 1);
    add("E_b", 2, 1, 0, 1, 0, 0, 8'h00, 0, 0, 1);
    add("E_c", 2, 1, 0, 1, 0, 0, 8'h00, 0, 0, 1);

    t_rst = 1; t_en = 1; t_v = 0; t_code = 0;
    step(0, nul);
    mchk = 1;
    foreach (tbl[i]) begin
      t_rst = tbl[i].rst; t_en = tbl[i].en; t_v = tbl[i].v; t_code = tbl[i].code;
      step(1, tbl[i]);
    end

    // Random traffic: order and hold length are checked every cycle by the model.
    t_rst = 1; t_en = 1; t_v = 0;
    step(0, nul);
    t_rst = 0;
    for (int k = 0; k < NI; k++) begin pushes[k] = 0; vcyc[k] = 0; end
    for (int c = 0; c < 6000 && pushes[1] < 200; c++) begin
      t_en = ($urandom_range(0, 3) != 0);
      t_v = 1'($urandom_range(0, 1));
      t_code = 3'($urandom_range(0, 7));
      step(0, nul);
    end
    chk("rand_pushes", 32'(pushes[1] >= 200), 32'd1);
    t_en = 1; t_v = 0;
    for (int c = 0; c < 60; c++) step(0, nul);
    for (int k = 0; k < NI; k++)
      chk($sformatf("rand_hold_cycles[%0d]", k), 32'(vcyc[k]), 32'(hv[k] * pushes[k]));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
